// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle around the stream_fifo: upstream (sIn) and downstream (sOut) sides.
// The FIFO takes the slave modport; the producer/consumer environment takes master.
interface stream_fifo_if #(
   parameter int unsigned N = 8
);
   logic [N-1:0] sIn;
   logic         sIn_valid;
   logic         sIn_ready;
   logic [N-1:0] sOut;
   logic         sOut_valid;
   logic         sOut_ready;

   modport master (
      output sIn, sIn_valid, sOut_ready,
      input  sIn_ready, sOut, sOut_valid
   );

   modport slave (
      input  sIn, sIn_valid, sOut_ready,
      output sIn_ready, sOut, sOut_valid
   );
endinterface

// File: rtl/stream_fifo.sv
// Elastic valid/ready FIFO feeding the stream-pop primitives.
// Optional fall-through when empty: define STREAM_FIFO_BYPASS_EN.
module stream_fifo #(
   parameter int unsigned N     = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          nrst,
   stream_fifo_if.slave  s,
   output logic [AW:0]   count
);
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [N-1:0] mem_q [DEPTH];
   logic         full, empty, push, pop, wr_en, rd_en;

   // Extra wrap bit distinguishes full from empty when the low bits match.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign count = wr_ptr_q - rd_ptr_q;

   assign s.sIn_ready = nrst && !full;
   assign push        = s.sIn_valid && s.sIn_ready;
   assign pop         = s.sOut_valid && s.sOut_ready;

`ifdef STREAM_FIFO_BYPASS_EN
   logic bypass;
   assign bypass       = empty && s.sIn_valid && nrst;
   assign s.sOut_valid = !empty || bypass;
   assign s.sOut       = empty ? s.sIn : mem_q[rd_ptr_q[AW-1:0]];
   // A word consumed straight through never touches storage.
   assign wr_en        = push && !(bypass && s.sOut_ready);
   assign rd_en        = pop && !empty;
`else
   assign s.sOut_valid = !empty;
   assign s.sOut       = mem_q[rd_ptr_q[AW-1:0]];
   assign wr_en        = push;
   assign rd_en        = pop;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s.sIn;
   end
endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo; follows STREAM_FIFO_BYPASS_EN when defined.
module tb_stream_fifo;
   logic       clk;
   logic       nrst;
   logic [2:0] count;
   int         checks;
   int         failures;

   stream_fifo_if #(.N(8)) bus ();

   stream_fifo #(
      .N    (8),
      .DEPTH(4),
      .AW   (2)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .s    (bus),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      bus.sIn = 8'hEE;
      bus.sIn_valid = 1'b1;
      bus.sOut_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.sIn_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus.sIn_ready);
         end
         checks++;
         if (bus.sOut_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.sOut_valid);
         end
         checks++;
         if (count !== 3'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", count);
         end
         tick();
      end
      nrst = 1'b1;
      bus.sIn_valid = 1'b0;
      #1;
      checks++;
      if (bus.sIn_ready !== 1'b1) begin
         failures++; $display("FAIL release_in_ready got=%0b exp=1", bus.sIn_ready);
      end
      tick();
   endtask

   task automatic test_streaming();
      bus.sOut_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         logic [7:0] w;
         w = 8'(i);
         bus.sIn = w;
         bus.sIn_valid = 1'b1;
         #1;
         checks++;
         if (bus.sIn_ready !== 1'b1) begin
            failures++; $display("FAIL stream_in_ready got=%0b exp=1", bus.sIn_ready);
         end
`ifdef STREAM_FIFO_BYPASS_EN
         checks++;
         if (bus.sOut_valid !== 1'b1 || bus.sOut !== w || count !== 3'd0) begin
            failures++;
            $display("FAIL stream_bypass got=v%0b d%0h c%0d exp=v1 d%0h c0",
                     bus.sOut_valid, bus.sOut, count, w);
         end
`else
         if (i == 1) begin
            checks++;
            if (bus.sOut_valid !== 1'b0 || count !== 3'd0) begin
               failures++;
               $display("FAIL stream_first got=v%0b c%0d exp=v0 c0", bus.sOut_valid, count);
            end
         end else begin
            checks++;
            if (bus.sOut_valid !== 1'b1 || bus.sOut !== w - 8'd1 || count !== 3'd1) begin
               failures++;
               $display("FAIL stream_word got=v%0b d%0h c%0d exp=v1 d%0h c1",
                        bus.sOut_valid, bus.sOut, count, w - 8'd1);
            end
         end
`endif
         tick();
      end
      bus.sIn_valid = 1'b0;
      #1;
`ifndef STREAM_FIFO_BYPASS_EN
      checks++;
      if (bus.sOut_valid !== 1'b1 || bus.sOut !== 8'd8) begin
         failures++;
         $display("FAIL stream_last got=v%0b d%0h exp=v1 d8", bus.sOut_valid, bus.sOut);
      end
      tick();
`endif
      checks++;
      if (count !== 3'd0 || bus.sOut_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_drained got=c%0d v%0b exp=c0 v0", count, bus.sOut_valid);
      end
      tick();
   endtask

   task automatic test_fill();
      logic accepted;
      bus.sOut_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.sIn = 8'(10 + k);
         bus.sIn_valid = 1'b1;
         #1;
         checks++;
         if (bus.sIn_ready !== 1'b1 || count !== 3'(k)) begin
            failures++;
            $display("FAIL fill_push got=r%0b c%0d exp=r1 c%0d", bus.sIn_ready, count, k);
         end
         tick();
      end
      bus.sIn = 8'd14;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (count !== 3'd4 || bus.sIn_ready !== 1'b0 || bus.sOut !== 8'd10) begin
            failures++;
            $display("FAIL fill_full got=c%0d r%0b d%0h exp=c4 r0 d0a",
                     count, bus.sIn_ready, bus.sOut);
         end
         tick();
      end
      bus.sOut_ready = 1'b1;
      accepted = 1'b0;
      for (int j = 0; j < 5; j++) begin
         bus.sIn_valid = !accepted;
         #1;
         checks++;
         if (bus.sOut_valid !== 1'b1 || bus.sOut !== 8'(10 + j)) begin
            failures++;
            $display("FAIL fill_order got=v%0b d%0h exp=v1 d%0h",
                     bus.sOut_valid, bus.sOut, 8'(10 + j));
         end
         if (bus.sIn_valid && bus.sIn_ready) accepted = 1'b1;
         tick();
      end
      bus.sIn_valid = 1'b0;
      #1;
      checks++;
      if (accepted !== 1'b1 || count !== 3'd0 || bus.sOut_valid !== 1'b0) begin
         failures++;
         $display("FAIL fill_end got=a%0b c%0d v%0b exp=a1 c0 v0",
                  accepted, count, bus.sOut_valid);
      end
      tick();
   endtask

   task automatic test_full_simultaneous();
      bus.sOut_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.sIn = 8'(20 + k);
         bus.sIn_valid = 1'b1;
         tick();
      end
      bus.sIn = 8'd24;
      bus.sOut_ready = 1'b1;
      #1;
      checks++;
      if (count !== 3'd4 || bus.sIn_ready !== 1'b0 || bus.sOut !== 8'd20) begin
         failures++;
         $display("FAIL full_simul_pre got=c%0d r%0b d%0h exp=c4 r0 d14",
                  count, bus.sIn_ready, bus.sOut);
      end
      tick();
      checks++;
      if (count !== 3'd3 || bus.sIn_ready !== 1'b1 || bus.sOut !== 8'd21) begin
         failures++;
         $display("FAIL full_pop_only got=c%0d r%0b d%0h exp=c3 r1 d15",
                  count, bus.sIn_ready, bus.sOut);
      end
      tick();
      bus.sIn_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         if (j == 0) begin
            checks++;
            if (count !== 3'd3) begin
               failures++; $display("FAIL both_fire_count got=%0d exp=3", count);
            end
         end
         checks++;
         if (bus.sOut !== 8'(22 + j)) begin
            failures++;
            $display("FAIL full_drain got=%0h exp=%0h", bus.sOut, 8'(22 + j));
         end
         tick();
      end
      checks++;
      if (count !== 3'd0) begin
         failures++; $display("FAIL full_end_count got=%0d exp=0", count);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] lfsr;
      logic [7:0] exp_w;
      int         in_idx;
      int         out_idx;
      int         max_cnt;
      lfsr = 8'hA5;
      in_idx = 0;
      out_idx = 0;
      max_cnt = 0;
      for (int cyc = 0; cyc < 300 && out_idx < 13; cyc++) begin
         bus.sIn = 8'(8'h30 + in_idx);
         bus.sIn_valid = (in_idx < 13);
         bus.sOut_ready = lfsr[0];
         lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         #1;
         if (int'(count) > max_cnt) max_cnt = int'(count);
         if (bus.sOut_valid && bus.sOut_ready) begin
            exp_w = 8'(8'h30 + out_idx);
            checks++;
            if (bus.sOut !== exp_w) begin
               failures++; $display("FAIL wrap_order got=%0h exp=%0h", bus.sOut, exp_w);
            end
            out_idx++;
         end
         if (bus.sIn_valid && bus.sIn_ready) in_idx++;
         tick();
      end
      bus.sIn_valid = 1'b0;
      #1;
      checks++;
      if (out_idx != 13) begin
         failures++; $display("FAIL wrap_timeout got=%0d exp=13", out_idx);
      end
      checks++;
      if (max_cnt > 4) begin
         failures++; $display("FAIL wrap_max_count got=%0d exp<=4", max_cnt);
      end
      checks++;
      if (count !== 3'd0) begin
         failures++; $display("FAIL wrap_end_count got=%0d exp=0", count);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      bus.sOut_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.sIn = 8'(8'h40 + k);
         bus.sIn_valid = 1'b1;
         tick();
      end
      bus.sIn_valid = 1'b0;
      #1;
      checks++;
      if (count !== 3'd3) begin
         failures++; $display("FAIL midrst_pre_count got=%0d exp=3", count);
      end
      nrst = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || bus.sOut_valid !== 1'b0 || bus.sIn_ready !== 1'b0) begin
         failures++;
         $display("FAIL midrst_async got=c%0d v%0b r%0b exp=c0 v0 r0",
                  count, bus.sOut_valid, bus.sIn_ready);
      end
      nrst = 1'b1;
      #1;
      checks++;
      if (bus.sIn_ready !== 1'b1) begin
         failures++; $display("FAIL midrst_release got=%0b exp=1", bus.sIn_ready);
      end
      tick();
      bus.sIn = 8'h55;
      bus.sIn_valid = 1'b1;
      tick();
      bus.sIn_valid = 1'b0;
      bus.sOut_ready = 1'b1;
      #1;
      checks++;
      if (bus.sOut_valid !== 1'b1 || bus.sOut !== 8'h55 || count !== 3'd1) begin
         failures++;
         $display("FAIL midrst_first got=v%0b d%0h c%0d exp=v1 d55 c1",
                  bus.sOut_valid, bus.sOut, count);
      end
      tick();
      checks++;
      if (count !== 3'd0) begin
         failures++; $display("FAIL midrst_end got=%0d exp=0", count);
      end
   endtask

   task automatic test_bypass();
      bus.sIn = 8'h2A;
      bus.sIn_valid = 1'b1;
      bus.sOut_ready = 1'b1;
      #1;
`ifdef STREAM_FIFO_BYPASS_EN
      checks++;
      if (bus.sOut_valid !== 1'b1 || bus.sOut !== 8'h2A || count !== 3'd0) begin
         failures++;
         $display("FAIL bypass_same got=v%0b d%0h c%0d exp=v1 d2a c0",
                  bus.sOut_valid, bus.sOut, count);
      end
      tick();
      bus.sIn_valid = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || bus.sOut_valid !== 1'b0) begin
         failures++;
         $display("FAIL bypass_after got=c%0d v%0b exp=c0 v0", count, bus.sOut_valid);
      end
`else
      checks++;
      if (bus.sOut_valid !== 1'b0) begin
         failures++; $display("FAIL nobypass_same got=%0b exp=0", bus.sOut_valid);
      end
      tick();
      bus.sIn_valid = 1'b0;
      #1;
      checks++;
      if (bus.sOut_valid !== 1'b1 || bus.sOut !== 8'h2A || count !== 3'd1) begin
         failures++;
         $display("FAIL nobypass_next got=v%0b d%0h c%0d exp=v1 d2a c1",
                  bus.sOut_valid, bus.sOut, count);
      end
      tick();
      checks++;
      if (count !== 3'd0) begin
         failures++; $display("FAIL nobypass_end got=%0d exp=0", count);
      end
`endif
      tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_streaming();
      test_fill();
      test_full_simultaneous();
      test_wrap();
      test_mid_reset();
      test_bypass();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
